// File: rtl/run_sequencer.sv
// run_sequencer: sequences one simulation run of an example DUT.
// It holds the DUT in reset, then enables it for a fixed number of cycles.
// After the enabled cycles it drains and then reports done.
// Pause freezes the run phase, and abort ends the run early.
module run_sequencer #(
  parameter int unsigned RESET_CYCLES = 4,
  parameter int unsigned RUN_CYCLES   = 100,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned MARK_CYCLE   = 50,
  parameter int unsigned CW           = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_i,
  input  logic          pause_i,
  input  logic          abort_i,
  output logic          dut_reset_o,
  output logic          run_en_o,
  output logic [CW-1:0] cycle_cnt_o,
  output logic          mark_pulse_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          aborted_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  // One phase counter times both RST and DRAIN, so it is sized for the longer of the two.
  localparam int unsigned PHASE_MAX = (RESET_CYCLES > DRAIN_CYCLES) ? RESET_CYCLES : DRAIN_CYCLES;
  localparam int unsigned PW        = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;

  localparam logic [PW-1:0] RST_LAST   = PW'(RESET_CYCLES - 1);
  localparam logic [PW-1:0] DRAIN_LAST = PW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [CW-1:0] RUN_LAST   = CW'(RUN_CYCLES - 1);
  localparam logic [CW-1:0] MARK_VAL   = CW'(MARK_CYCLE);
  localparam bit            HAS_DRAIN  = (DRAIN_CYCLES > 0);

  // A mark at or beyond the run length can never be reached, so it is disabled outright.
  localparam bit            MARK_EN    = (MARK_CYCLE < RUN_CYCLES);

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          aborted_q, aborted_d;
  logic          run_en;

  // Next-state logic. Abort takes priority over phase completion, and starting a run clears the previous run's results.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    aborted_d = aborted_q;
    run_en    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d   = S_RST;
          phase_d   = '0;
          cnt_d     = '0;
          aborted_d = 1'b0;
        end
      end
      S_RST: begin
        if (abort_i) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
        end else if (phase_q == RST_LAST) begin
          state_d = S_RUN;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      S_RUN: begin
        run_en = !pause_i && !abort_i;
        if (abort_i) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
        end else if (run_en) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == RUN_LAST) begin
            state_d = HAS_DRAIN ? S_DRAIN : S_DONE;
            phase_d = '0;
          end
        end
      end
      S_DRAIN: begin
        if (abort_i) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
        end else if (phase_q == DRAIN_LAST) begin
          state_d = S_DONE;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, phase, cycle count and abort flag registers, with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      cnt_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      aborted_q <= aborted_d;
    end
  end

  assign dut_reset_o  = (state_q == S_IDLE) || (state_q == S_RST);
  assign run_en_o     = run_en;
  assign cycle_cnt_o  = cnt_q;
  assign mark_pulse_o = MARK_EN && run_en && (cnt_q == MARK_VAL);
  assign busy_o       = (state_q == S_RST) || (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done_o       = (state_q == S_DONE);
  assign aborted_o    = aborted_q;

  cover property (@(posedge clk) disable iff (reset) (state_q == S_RUN) && (state_d == S_DRAIN));
  cover property (@(posedge clk) disable iff (reset) (state_q != S_DONE) && (state_d == S_DONE) && aborted_d);
  cover property (@(posedge clk) disable iff (reset) (state_q == S_RUN) && pause_i);

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: scenario tasks for run_sequencer with a run-result scoreboard.
// The expected results for each run are pushed when the run is started.
// They are popped and compared once the DUT reports done.
module tb_run_sequencer;

  localparam int RESET_CYCLES = 4;
  localparam int RUN_CYCLES   = 100;
  localparam int DRAIN_CYCLES = 2;
  localparam int MARK_CYCLE   = 50;
  localparam int CW           = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_i, pause_i, abort_i;
  logic          dut_reset_o, run_en_o, mark_pulse_o, busy_o, done_o, aborted_o;
  logic [CW-1:0] cycle_cnt_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int rstCycles;
    int runCycles;
    int busyCycles;
    int finalCnt;
    int aborted;
    int marks;
    int markCnt;
  } runExp_t;

  typedef struct {
    int rstCycles;
    int runCycles;
    int busyCycles;
    int finalCnt;
    int aborted;
    int marks;
    int markCnt;
    int timedOut;
    int viol;
    int firstDone;
    int firstAborted;
    int firstCnt;
    int firstDutReset;
  } runObs_t;

  runExp_t expQ[$];

  run_sequencer #(
    .RESET_CYCLES(RESET_CYCLES),
    .RUN_CYCLES  (RUN_CYCLES),
    .DRAIN_CYCLES(DRAIN_CYCLES),
    .MARK_CYCLE  (MARK_CYCLE),
    .CW          (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_i),
    .pause_i     (pause_i),
    .abort_i     (abort_i),
    .dut_reset_o (dut_reset_o),
    .run_en_o    (run_en_o),
    .cycle_cnt_o (cycle_cnt_o),
    .mark_pulse_o(mark_pulse_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .aborted_o   (aborted_o)
  );

  always #5 clk = ~clk;

  // Starts a run, then drives pause, abort or start at chosen cycle counts, and measures the run until done or timeout.
  task automatic observeRun(input int pauseAt, input int pauseLen, input int abortAt,
                            input int startAt, output runObs_t o);
    int  pausedSoFar = 0;
    bit  abortSent = 0;
    bit  startSent = 0;
    bit  inRun;
    o = '{default: 0};
    o.markCnt  = -1;
    o.timedOut = 1;
    @(negedge clk);
    start_i = 1'b1; pause_i = 1'b0; abort_i = 1'b0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      start_i = 1'b0; pause_i = 1'b0; abort_i = 1'b0;
      inRun = busy_o && !dut_reset_o && (cycle_cnt_o < RUN_CYCLES);
      if (pauseAt >= 0 && inRun && cycle_cnt_o == pauseAt && pausedSoFar < pauseLen) begin
        pause_i = 1'b1;
        pausedSoFar++;
      end
      if (abortAt >= 0 && inRun && cycle_cnt_o == abortAt && !abortSent) begin
        abort_i = 1'b1;
        abortSent = 1;
      end
      if (startAt >= 0 && inRun && cycle_cnt_o == startAt && !startSent) begin
        start_i = 1'b1;
        startSent = 1;
      end
      #1;
      if (cyc == 0) begin
        o.firstDone     = int'(done_o);
        o.firstAborted  = int'(aborted_o);
        o.firstCnt      = int'(cycle_cnt_o);
        o.firstDutReset = int'(dut_reset_o);
      end
      if (busy_o) o.busyCycles++;
      if (busy_o && dut_reset_o) o.rstCycles++;
      if (run_en_o) o.runCycles++;
      if (run_en_o && dut_reset_o) o.viol++;
      if (pause_i && (run_en_o || cycle_cnt_o != pauseAt)) o.viol++;
      if (mark_pulse_o) begin
        o.marks++;
        o.markCnt = int'(cycle_cnt_o);
      end
      if (done_o) begin
        o.finalCnt = int'(cycle_cnt_o);
        o.aborted  = int'(aborted_o);
        o.timedOut = 0;
        break;
      end
    end
    start_i = 1'b0; pause_i = 1'b0; abort_i = 1'b0;
  endtask

  // Checks that every output holds its reset value while reset is applied.
  task automatic test_reset();
    reset = 1'b1; start_i = 1'b0; pause_i = 1'b0; abort_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (dut_reset_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_dut_reset got %b want 1", dut_reset_o); end
    checks++; if (run_en_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_run_en got %b want 0", run_en_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done_o); end
    checks++; if (aborted_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_aborted got %b want 0", aborted_o); end
    checks++; if (cycle_cnt_o !== '0) begin errors++; $display("[TB] FAIL reset_cycle_cnt got %0d want 0", cycle_cnt_o); end
    checks++; if (mark_pulse_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_mark got %b want 0", mark_pulse_o); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Checks a plain run: phase lengths, final count and a single mark at the mark cycle.
  task automatic test_full_run();
    runObs_t o;
    runExp_t e;
    expQ.push_back('{RESET_CYCLES, RUN_CYCLES, RESET_CYCLES + RUN_CYCLES + DRAIN_CYCLES,
                     RUN_CYCLES, 0, 1, MARK_CYCLE});
    observeRun(-1, 0, -1, -1, o);
    e = expQ.pop_front();
    checks++; if (o.timedOut != 0) begin errors++; $display("[TB] FAIL full_timeout got %0d want 0", o.timedOut); end
    checks++; if (o.rstCycles != e.rstCycles) begin errors++; $display("[TB] FAIL full_rst got %0d want %0d", o.rstCycles, e.rstCycles); end
    checks++; if (o.runCycles != e.runCycles) begin errors++; $display("[TB] FAIL full_run got %0d want %0d", o.runCycles, e.runCycles); end
    checks++; if (o.busyCycles != e.busyCycles) begin errors++; $display("[TB] FAIL full_busy got %0d want %0d", o.busyCycles, e.busyCycles); end
    checks++; if (o.finalCnt != e.finalCnt) begin errors++; $display("[TB] FAIL full_cnt got %0d want %0d", o.finalCnt, e.finalCnt); end
    checks++; if (o.aborted != e.aborted) begin errors++; $display("[TB] FAIL full_aborted got %0d want %0d", o.aborted, e.aborted); end
    checks++; if (o.marks != e.marks) begin errors++; $display("[TB] FAIL full_marks got %0d want %0d", o.marks, e.marks); end
    checks++; if (o.markCnt != e.markCnt) begin errors++; $display("[TB] FAIL full_mark_cnt got %0d want %0d", o.markCnt, e.markCnt); end
    checks++; if (o.viol != 0) begin errors++; $display("[TB] FAIL full_run_en_in_reset got %0d want 0", o.viol); end
  endtask

  // Pauses for 10 cycles at count 20: the run phase stretches and the count holds.
  task automatic test_pause();
    runObs_t o;
    runExp_t e;
    expQ.push_back('{RESET_CYCLES, RUN_CYCLES, RESET_CYCLES + RUN_CYCLES + 10 + DRAIN_CYCLES,
                     RUN_CYCLES, 0, 1, MARK_CYCLE});
    observeRun(20, 10, -1, -1, o);
    e = expQ.pop_front();
    checks++; if (o.timedOut != 0) begin errors++; $display("[TB] FAIL pause_timeout got %0d want 0", o.timedOut); end
    checks++; if (o.viol != 0) begin errors++; $display("[TB] FAIL pause_hold got %0d violations want 0", o.viol); end
    checks++; if (o.runCycles != e.runCycles) begin errors++; $display("[TB] FAIL pause_run got %0d want %0d", o.runCycles, e.runCycles); end
    checks++; if (o.busyCycles != e.busyCycles) begin errors++; $display("[TB] FAIL pause_busy got %0d want %0d", o.busyCycles, e.busyCycles); end
    checks++; if (o.finalCnt != e.finalCnt) begin errors++; $display("[TB] FAIL pause_cnt got %0d want %0d", o.finalCnt, e.finalCnt); end
    checks++; if (o.marks != e.marks) begin errors++; $display("[TB] FAIL pause_marks got %0d want %0d", o.marks, e.marks); end
  endtask

  // Aborts at count 30: done on the next cycle with the count frozen at 30.
  task automatic test_abort();
    runObs_t o;
    runExp_t e;
    expQ.push_back('{RESET_CYCLES, 30, RESET_CYCLES + 31, 30, 1, 0, -1});
    observeRun(-1, 0, 30, -1, o);
    e = expQ.pop_front();
    checks++; if (o.timedOut != 0) begin errors++; $display("[TB] FAIL abort_timeout got %0d want 0", o.timedOut); end
    checks++; if (o.busyCycles != e.busyCycles) begin errors++; $display("[TB] FAIL abort_busy got %0d want %0d", o.busyCycles, e.busyCycles); end
    checks++; if (o.runCycles != e.runCycles) begin errors++; $display("[TB] FAIL abort_run got %0d want %0d", o.runCycles, e.runCycles); end
    checks++; if (o.finalCnt != e.finalCnt) begin errors++; $display("[TB] FAIL abort_cnt got %0d want %0d", o.finalCnt, e.finalCnt); end
    checks++; if (o.aborted != e.aborted) begin errors++; $display("[TB] FAIL abort_flag got %0d want %0d", o.aborted, e.aborted); end
    checks++; if (o.marks != e.marks) begin errors++; $display("[TB] FAIL abort_marks got %0d want %0d", o.marks, e.marks); end
  endtask

  // Restarts from an aborted DONE, which clears the results, and checks that a start pulse mid-run is ignored.
  task automatic test_restart();
    runObs_t o;
    runExp_t e;
    expQ.push_back('{RESET_CYCLES, RUN_CYCLES, RESET_CYCLES + RUN_CYCLES + DRAIN_CYCLES,
                     RUN_CYCLES, 0, 1, MARK_CYCLE});
    observeRun(-1, 0, -1, 10, o);
    e = expQ.pop_front();
    checks++; if (o.firstDone != 0) begin errors++; $display("[TB] FAIL restart_done_clr got %0d want 0", o.firstDone); end
    checks++; if (o.firstAborted != 0) begin errors++; $display("[TB] FAIL restart_abort_clr got %0d want 0", o.firstAborted); end
    checks++; if (o.firstCnt != 0) begin errors++; $display("[TB] FAIL restart_cnt_clr got %0d want 0", o.firstCnt); end
    checks++; if (o.firstDutReset != 1) begin errors++; $display("[TB] FAIL restart_dut_reset got %0d want 1", o.firstDutReset); end
    checks++; if (o.timedOut != 0) begin errors++; $display("[TB] FAIL restart_timeout got %0d want 0", o.timedOut); end
    checks++; if (o.rstCycles != e.rstCycles) begin errors++; $display("[TB] FAIL restart_rst got %0d want %0d", o.rstCycles, e.rstCycles); end
    checks++; if (o.busyCycles != e.busyCycles) begin errors++; $display("[TB] FAIL restart_busy got %0d want %0d", o.busyCycles, e.busyCycles); end
    checks++; if (o.finalCnt != e.finalCnt) begin errors++; $display("[TB] FAIL restart_cnt got %0d want %0d", o.finalCnt, e.finalCnt); end
    checks++; if (o.aborted != e.aborted) begin errors++; $display("[TB] FAIL restart_aborted got %0d want %0d", o.aborted, e.aborted); end
  endtask

  // In DONE, abort alone is ignored, while start together with abort begins a new run.
  task automatic test_done_inputs();
    @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    #1;
    checks++; if (done_o !== 1'b1) begin errors++; $display("[TB] FAIL done_abort_done got %b want 1", done_o); end
    checks++; if (aborted_o !== 1'b0) begin errors++; $display("[TB] FAIL done_abort_flag got %b want 0", aborted_o); end
    checks++; if (cycle_cnt_o !== CW'(RUN_CYCLES)) begin errors++; $display("[TB] FAIL done_cnt_hold got %0d want %0d", cycle_cnt_o, RUN_CYCLES); end
    @(negedge clk);
    start_i = 1'b1; abort_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; abort_i = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL start_wins_busy got %b want 1", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL start_wins_done got %b want 0", done_o); end
    checks++; if (aborted_o !== 1'b0) begin errors++; $display("[TB] FAIL start_wins_aborted got %b want 0", aborted_o); end
    checks++; if (dut_reset_o !== 1'b1) begin errors++; $display("[TB] FAIL start_wins_dut_reset got %b want 1", dut_reset_o); end
  endtask

  // Applies reset at count 70; it acts only at the next edge and returns every output to its reset value.
  task automatic test_reset_mid_run();
    bit found = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk);
      #1;
      if (run_en_o && cycle_cnt_o == 70) begin
        found = 1;
        break;
      end
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL midreset_reach70 got 0 want 1"); end
    reset = 1'b1;
    #1;
    checks++; if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL midreset_sync got busy %b want 1", busy_o); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (dut_reset_o !== 1'b1) begin errors++; $display("[TB] FAIL midreset_dut_reset got %b want 1", dut_reset_o); end
    checks++; if (run_en_o !== 1'b0) begin errors++; $display("[TB] FAIL midreset_run_en got %b want 0", run_en_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy got %b want 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL midreset_done got %b want 0", done_o); end
    checks++; if (aborted_o !== 1'b0) begin errors++; $display("[TB] FAIL midreset_aborted got %b want 0", aborted_o); end
    checks++; if (cycle_cnt_o !== '0) begin errors++; $display("[TB] FAIL midreset_cnt got %0d want 0", cycle_cnt_o); end
    checks++; if (mark_pulse_o !== 1'b0) begin errors++; $display("[TB] FAIL midreset_mark got %b want 0", mark_pulse_o); end
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    test_reset();
    test_full_run();
    test_pause();
    test_abort();
    test_restart();
    test_done_inputs();
    test_reset_mid_run();
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_leftover got %0d want 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
